// File: rtl/beam_summer_if.sv
// Handshake and data bundle between the delay stage, beam_summer and the downstream consumer.
interface beam_summer_if #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned DATA_W = 19,
  parameter int unsigned SUM_W  = DATA_W + 4
);
  logic                     sample_valid;
  logic signed [DATA_W-1:0] delayed_pcm_data_0;
  logic signed [DATA_W-1:0] delayed_pcm_data_1;
  logic signed [DATA_W-1:0] delayed_pcm_data_2;
  logic signed [DATA_W-1:0] delayed_pcm_data_3;
  logic signed [DATA_W-1:0] delayed_pcm_data_4;
  logic signed [DATA_W-1:0] delayed_pcm_data_5;
  logic signed [DATA_W-1:0] delayed_pcm_data_6;
  logic signed [DATA_W-1:0] delayed_pcm_data_7;
  logic signed [DATA_W-1:0] delayed_pcm_data_8;
  logic signed [DATA_W-1:0] delayed_pcm_data_9;
  logic signed [DATA_W-1:0] delayed_pcm_data_10;
  logic signed [DATA_W-1:0] delayed_pcm_data_11;
  logic signed [DATA_W-1:0] delayed_pcm_data_12;
  logic signed [DATA_W-1:0] delayed_pcm_data_13;
  logic signed [DATA_W-1:0] delayed_pcm_data_14;
  logic signed [DATA_W-1:0] delayed_pcm_data_15;
  logic [NUM_CH-1:0]        ch_enable;
  logic                     beam_ready;
  logic                     clear_overrun;
  logic signed [SUM_W-1:0]  beam_data;
  logic                     beam_valid;
  logic                     busy;
  logic                     overrun;

  modport master (
    output sample_valid, ch_enable, beam_ready, clear_overrun,
    output delayed_pcm_data_0, delayed_pcm_data_1, delayed_pcm_data_2, delayed_pcm_data_3,
    output delayed_pcm_data_4, delayed_pcm_data_5, delayed_pcm_data_6, delayed_pcm_data_7,
    output delayed_pcm_data_8, delayed_pcm_data_9, delayed_pcm_data_10, delayed_pcm_data_11,
    output delayed_pcm_data_12, delayed_pcm_data_13, delayed_pcm_data_14, delayed_pcm_data_15,
    input  beam_data, beam_valid, busy, overrun
  );

  modport slave (
    input  sample_valid, ch_enable, beam_ready, clear_overrun,
    input  delayed_pcm_data_0, delayed_pcm_data_1, delayed_pcm_data_2, delayed_pcm_data_3,
    input  delayed_pcm_data_4, delayed_pcm_data_5, delayed_pcm_data_6, delayed_pcm_data_7,
    input  delayed_pcm_data_8, delayed_pcm_data_9, delayed_pcm_data_10, delayed_pcm_data_11,
    input  delayed_pcm_data_12, delayed_pcm_data_13, delayed_pcm_data_14, delayed_pcm_data_15,
    output beam_data, beam_valid, busy, overrun
  );
endinterface

// File: rtl/beam_summer.sv
// Time-multiplexed delay-and-sum: snapshots 16 channels, accumulates one per clock, holds result on valid/ready.
// Optional macro BEAM_SUM_MEAN_EN: output the rounded mean instead of the raw sum.
module beam_summer #(
  parameter int unsigned NUM_CH = 16,
  parameter int unsigned DATA_W = 19,
  parameter int unsigned SUM_W  = DATA_W + 4
) (
  input logic          clk,
  input logic          rst,
  beam_summer_if.slave bus
);
  localparam int unsigned IDX_W = $clog2(NUM_CH);

  typedef enum logic [1:0] {S_IDLE, S_ACCUM, S_OUT} state_e;

  state_e                   state_q, state_d;
  logic [IDX_W-1:0]         idx_q, idx_d;
  logic signed [SUM_W-1:0]  acc_q, acc_d;
  logic signed [SUM_W-1:0]  beam_data_q, beam_data_d;
  logic signed [DATA_W-1:0] snap_q [NUM_CH];
  logic signed [DATA_W-1:0] snap_d [NUM_CH];
  logic signed [DATA_W-1:0] pcm_c  [NUM_CH];
  logic [NUM_CH-1:0]        mask_q, mask_d;
  logic                     beam_valid_q, beam_valid_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;
  logic signed [DATA_W-1:0] snap_sel_c;
  logic signed [SUM_W-1:0]  term_c, sum_c, result_c;
  logic                     capture_c, ovr_set_c;

  assign pcm_c[0]  = bus.delayed_pcm_data_0;
  assign pcm_c[1]  = bus.delayed_pcm_data_1;
  assign pcm_c[2]  = bus.delayed_pcm_data_2;
  assign pcm_c[3]  = bus.delayed_pcm_data_3;
  assign pcm_c[4]  = bus.delayed_pcm_data_4;
  assign pcm_c[5]  = bus.delayed_pcm_data_5;
  assign pcm_c[6]  = bus.delayed_pcm_data_6;
  assign pcm_c[7]  = bus.delayed_pcm_data_7;
  assign pcm_c[8]  = bus.delayed_pcm_data_8;
  assign pcm_c[9]  = bus.delayed_pcm_data_9;
  assign pcm_c[10] = bus.delayed_pcm_data_10;
  assign pcm_c[11] = bus.delayed_pcm_data_11;
  assign pcm_c[12] = bus.delayed_pcm_data_12;
  assign pcm_c[13] = bus.delayed_pcm_data_13;
  assign pcm_c[14] = bus.delayed_pcm_data_14;
  assign pcm_c[15] = bus.delayed_pcm_data_15;

  // Single shared adder: current channel term, sign-extended and gated by the captured mask.
  always_comb begin
    snap_sel_c = snap_q[idx_q];
    term_c     = mask_q[idx_q] ? {{(SUM_W-DATA_W){snap_sel_c[DATA_W-1]}}, snap_sel_c} : '0;
    sum_c      = acc_q + term_c;
  end

`ifdef BEAM_SUM_MEAN_EN
  localparam int unsigned RND = 1 << (IDX_W - 1);
  logic signed [SUM_W:0] wide_c, shr_c;
  always_comb begin
    wide_c   = {sum_c[SUM_W-1], sum_c} + (SUM_W+1)'(RND);
    shr_c    = wide_c >>> IDX_W;
    result_c = shr_c[SUM_W-1:0];
  end
`else
  assign result_c = sum_c;
`endif

  always_comb begin
    state_d      = state_q;
    idx_d        = idx_q;
    acc_d        = acc_q;
    snap_d       = snap_q;
    mask_d       = mask_q;
    beam_data_d  = beam_data_q;
    beam_valid_d = beam_valid_q;
    overrun_d    = overrun_q;
    capture_c    = 1'b0;
    ovr_set_c    = 1'b0;
    case (state_q)
      S_IDLE: capture_c = bus.sample_valid;
      S_ACCUM: begin
        acc_d     = sum_c;
        idx_d     = idx_q + 1'b1;
        ovr_set_c = bus.sample_valid;
        if (idx_q == IDX_W'(NUM_CH - 1)) begin
          beam_data_d  = result_c;
          beam_valid_d = 1'b1;
          state_d      = S_OUT;
        end
      end
      S_OUT: begin
        if (bus.beam_ready) begin
          beam_valid_d = 1'b0;
          state_d      = S_IDLE;
          capture_c    = bus.sample_valid;
        end else begin
          ovr_set_c = bus.sample_valid;
        end
      end
      default: state_d = S_IDLE;
    endcase
    // A capture in OUT overrides the return to IDLE, so back-to-back samples see no bubble.
    if (capture_c) begin
      snap_d  = pcm_c;
      mask_d  = bus.ch_enable;
      acc_d   = '0;
      idx_d   = '0;
      state_d = S_ACCUM;
    end
    if (bus.clear_overrun) overrun_d = 1'b0;
    if (ovr_set_c)         overrun_d = 1'b1;
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      idx_q        <= '0;
      acc_q        <= '0;
      mask_q       <= '0;
      beam_data_q  <= '0;
      beam_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
      for (int i = 0; i < int'(NUM_CH); i++) snap_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      acc_q        <= acc_d;
      mask_q       <= mask_d;
      beam_data_q  <= beam_data_d;
      beam_valid_q <= beam_valid_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
      snap_q       <= snap_d;
    end
  end

  assign bus.beam_data  = beam_data_q;
  assign bus.beam_valid = beam_valid_q;
  assign bus.busy       = busy_q;
  assign bus.overrun    = overrun_q;
endmodule

// File: doc/beam_summer.md
Name: beam_summer

Overview:
- Delay-and-sum back end: consumes the 16 delayed 19-bit PCM channels from the per-mic delay stage and produces one beamformed sample per input sample period.
- Time-multiplexed: snapshots all channels on a sample strobe, then accumulates one channel per clock through a single adder.
- Output is held under a valid/ready handshake for the downstream filter or serializer.

Parameters:
- NUM_CH, 16, number of channels; must be a power of two.
- DATA_W, 19, signed PCM width per channel.
- SUM_W, DATA_W+4, accumulator/output width (DATA_W + log2(NUM_CH)).

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sample_valid  in  1  one-cycle strobe; delayed_pcm_data_* valid this cycle
- delayed_pcm_data_0 .. delayed_pcm_data_15  in  DATA_W each  signed delayed channel samples
- ch_enable  in  NUM_CH  per-channel include mask; bit i gates channel i
- beam_ready  in  1  downstream accepts beam_data
- clear_overrun  in  1  synchronous clear of overrun
- beam_data  out  SUM_W  signed beamformed sample
- beam_valid  out  1  beam_data valid; held until accepted
- busy  out  1  high in ACCUM or OUT
- overrun  out  1  sticky: a sample strobe was dropped

Behaviour:
- Clock and reset: one clock, clk. rst is asynchronous and active-low. While rst is low: state=IDLE, beam_data=0, beam_valid=0, busy=0, overrun=0, acc=0, idx=0, snapshot registers=0.
- IDLE:
  - On sample_valid, register all 16 channels and ch_enable into snapshot registers.
  - Clear acc and set idx=0, then go to ACCUM.
  - Call this capture edge E0.
- ACCUM:
  - Each edge adds sign_extend(snap[idx]) to acc if mask[idx]=1; otherwise adds 0.
  - idx increments by 1.
  - The edge that processes idx=NUM_CH-1 (E16) loads beam_data from acc plus the final term, sets beam_valid=1 and goes to OUT.
  - Latency: beam_valid is high in the cycle after E16, i.e. 16 clocks after the capture edge.
- OUT:
  - beam_data and beam_valid hold stable until beam_valid && beam_ready at a rising edge.
  - On that edge beam_valid drops and the state returns to IDLE.
  - If sample_valid is also high on that edge, the new sample is captured there and the state goes directly to ACCUM (no drop, no bubble).
- busy = (state != IDLE), registered with the state.
- Arithmetic:
  - Two's-complement, sign-extended to SUM_W.
  - SUM_W guarantees no overflow: NUM_CH * (-2^(DATA_W-1)) fits exactly.
  - No saturation is required.
- Mask: sampled only at the capture edge; changes during ACCUM/OUT have no effect on the sample in flight. A mask of 0 produces beam_data=0 with a normal handshake.
- Overrun:
  - sample_valid in ACCUM, or in OUT without a completing handshake, sets overrun and the strobe is ignored.
  - Snapshot and acc are unaffected.
  - clear_overrun clears the flag. If clear_overrun and a new overrun event coincide, set wins.
- Reset mid-operation: rst low during ACCUM/OUT aborts immediately to the reset state. No partial output and no pending beam_valid after release.
- beam_ready is ignored outside OUT.

Optional Feature:
- Macro: BEAM_SUM_MEAN_EN.
- Defined: beam_data = (acc_final + 2^(log2(NUM_CH)-1)) >>> log2(NUM_CH). This is an arithmetic right shift with round-half-up (toward +inf), giving the mean over NUM_CH channels, sign-extended to SUM_W. The rounding add is done at SUM_W+1 bits to avoid overflow. Latency is unchanged; the rounding is folded into the E16 load.
- Undefined: beam_data is the raw full-precision sum.

Test Plan:
- All 16 channels=1, mask=0xFFFF, beam_ready=1 → beam_valid high for one cycle, 16 clocks after capture, beam_data=16 (with BEAM_SUM_MEAN_EN: 1).
- All channels=-262144, mask=0xFFFF → beam_data=-4194304 (0x400000 in 23 bits) (with BEAM_SUM_MEAN_EN: -262144).
- ch0=1000, ch1..15=5000, mask=0x0001; mask changed to 0xFFFF during ACCUM → beam_data=1000.
- beam_ready=0 for 30 cycles after beam_valid; strobe at cycle 20 after capture → beam_data stable, overrun=1. Then beam_ready=1 together with sample_valid → handshake completes and the new capture starts the same edge. clear_overrun → overrun=0.
- Capture, then rst low at accumulation step 7 for 2 cycles → all outputs 0. After release, a fresh sample with channels=3, mask=0xFFFF → beam_data=48.
- Channels alternating +100/-100, mask=0xFFFF → beam_data=0. With BEAM_SUM_MEAN_EN, channels all=7, mask=0x00FF → sum 56, beam_data=(56+8)>>>4=4.
